count_seq_checker: RTL and testbench

- Receive-side checker for the free-running 1..N wrap counter sequence produced by the counter blocks in this design.
- Samples a counter value on each valid cycle, hunts for and locks onto the expected MIN..MAX wrap sequence, then flags any deviation.
- Counts completed wraps and sequence errors for the debug/status path.
- All outputs are registered; one clock domain.

---
 rtl/count_seq_checker.sv | 132 +++++++++++++
 tb/tb_count_seq_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Receive-side checker for a MIN_VAL..MAX_VAL wrap counter sequence.
// Hunts for the sequence, locks after LOCK_CNT good successors, then flags deviations.
module count_seq_checker #(
  parameter int W          = 3,
  parameter int MIN_VAL    = 1,
  parameter int MAX_VAL    = 5,
  parameter int LOCK_CNT   = 2,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          seq_in,
  input  logic                  seq_valid,
  input  logic                  clr_counts,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [W-1:0]          expected,
  output logic [1:0]            state,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int           MW     = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
  localparam logic [W-1:0]  MIN_V  = W'(MIN_VAL);
  localparam logic [W-1:0]  MAX_V  = W'(MAX_VAL);

  function automatic logic [W-1:0] succ(input logic [W-1:0] x);
    return (x == MAX_V) ? MIN_V : x + W'(1);
  endfunction

  function automatic logic [WRAP_CNT_W-1:0] wrap_sat_inc(input logic [WRAP_CNT_W-1:0] c);
    return (&c) ? c : c + WRAP_CNT_W'(1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  logic [1:0]    state_n;
  logic [W-1:0]  prev_q, prev_n;
  logic [MW-1:0] match_q, match_n, match_inc;
  logic          in_range, hit, err_ev, wrap_ev;
  logic          locked_n;
  logic [W-1:0]  expected_n;

  assign in_range  = (seq_in >= MIN_V) && (seq_in <= MAX_V);
  assign hit       = (seq_in == succ(prev_q));
  assign match_inc = match_q + MW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      prev_q     <= '0;
      match_q    <= '0;
      locked     <= 1'b0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      state     <= state_n;
      prev_q    <= prev_n;
      match_q   <= match_n;
      locked    <= locked_n;
      expected  <= expected_n;
      err_pulse <= err_ev;
      if (clr_counts) begin
        wrap_count <= '0;
        err_count  <= '0;
      end else begin
        if (wrap_ev) wrap_count <= wrap_sat_inc(wrap_count);
        if (err_ev)  err_count  <= err_sat_inc(err_count);
      end
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = prev_q;
    match_n = match_q;
    err_ev  = 1'b0;
    wrap_ev = 1'b0;
    case (state)
      HUNT: begin
        if (seq_valid && in_range) begin
          state_n = SYNC;
          prev_n  = seq_in;
          match_n = '0;
        end
      end
      SYNC: begin
        if (seq_valid) begin
          if (hit) begin
            prev_n  = seq_in;
            match_n = match_inc;
            if (match_inc == LOCK_M) state_n = LOCKED;
          end else if (in_range) begin
            prev_n  = seq_in;
            match_n = '0;
          end else begin
            state_n = HUNT;
          end
        end
      end
      LOCKED: begin
        if (seq_valid) begin
          if (hit) begin
            prev_n  = seq_in;
            wrap_ev = (seq_in == MIN_V);
          end else begin
            // Bad sample is dropped; HUNT reseeds from the next valid sample.
            err_ev  = 1'b1;
            state_n = HUNT;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_comb begin
    locked_n   = (state_n == LOCKED);
    expected_n = (state_n == HUNT) ? '0 : succ(prev_n);
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed test-plan sequences plus random traffic,
// every cycle compared against a run-length based reference model.
module tb_count_seq_checker;
  localparam int W = 3, MIN_VAL = 1, MAX_VAL = 5, LOCK_CNT = 2;
  localparam int WRAP_CNT_W = 3, ERR_CNT_W = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [W-1:0]          seq_in = '0;
  logic                  seq_valid = 1'b0;
  logic                  clr_counts = 1'b0;
  logic                  locked, err_pulse;
  logic [W-1:0]          expected;
  logic [1:0]            state;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [ERR_CNT_W-1:0]  err_count;

  count_seq_checker #(
    .W(W), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .LOCK_CNT(LOCK_CNT),
    .WRAP_CNT_W(WRAP_CNT_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .seq_in(seq_in), .seq_valid(seq_valid),
    .clr_counts(clr_counts), .locked(locked), .err_pulse(err_pulse),
    .expected(expected), .state(state), .wrap_count(wrap_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: run < 0 means no seed yet, otherwise the number of
  // good successors seen since the seed; lk marks an established lock.
  bit m_lk;
  int m_run, m_prev, m_wrap, m_err;
  bit m_pulse;

  function automatic int succ(input int x);
    return (x == MAX_VAL) ? MIN_VAL : x + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input int d, input bit c);
    bit inc_w = 0, inc_e = 0;
    if (r) begin
      m_lk = 0; m_run = -1; m_prev = 0; m_wrap = 0; m_err = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (m_lk) begin
        if (d == succ(m_prev)) begin
          m_prev = d;
          inc_w = (d == MIN_VAL);
        end else begin
          m_lk = 0; m_run = -1; m_pulse = 1; inc_e = 1;
        end
      end else if (m_run < 0) begin
        if (d >= MIN_VAL && d <= MAX_VAL) begin m_prev = d; m_run = 0; end
      end else if (d == succ(m_prev)) begin
        m_prev = d; m_run++;
        if (m_run == LOCK_CNT) m_lk = 1;
      end else if (d >= MIN_VAL && d <= MAX_VAL) begin
        m_prev = d; m_run = 0;
      end else begin
        m_run = -1;
      end
    end
    if (c) begin
      m_wrap = 0; m_err = 0;
    end else begin
      if (inc_w && m_wrap < (1 << WRAP_CNT_W) - 1) m_wrap++;
      if (inc_e && m_err < (1 << ERR_CNT_W) - 1) m_err++;
    end
  endtask

  task automatic compare_all();
    int ms;
    ms = m_lk ? 2 : (m_run < 0 ? 0 : 1);
    chk("state", state, ms);
    chk("locked", locked, m_lk);
    chk("err_pulse", err_pulse, m_pulse);
    chk("expected", expected, ms == 0 ? 0 : succ(m_prev));
    chk("wrap_count", wrap_count, m_wrap);
    chk("err_count", err_count, m_err);
  endtask

  task automatic step(input bit r, input bit v, input int d, input bit c);
    @(negedge clk);
    rst = r; seq_valid = v; seq_in = W'(d); clr_counts = c;
    @(posedge clk);
    model(r, v, d, c);
    #1;
    compare_all();
  endtask

  task automatic send(input int d);
    step(0, 1, d, 0);
  endtask

  initial begin
    // Test 1: lock and wrap
    step(1, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_expected", expected, 0);
    chk("rst_wrap", wrap_count, 0);
    send(1);
    chk("t1_sync", state, 1);
    send(2); send(3);
    chk("t1_locked", locked, 1);
    send(4); send(5); send(1);
    chk("t1_wrap", wrap_count, 1);
    send(2);
    chk("t1_exp", expected, 3);
    chk("t1_err", err_count, 0);

    // Test 2: error while locked
    step(1, 0, 0, 0);
    send(1); send(2); send(3); send(5);
    chk("t2_pulse", err_pulse, 1);
    chk("t2_errc", err_count, 1);
    chk("t2_state", state, 0);
    chk("t2_exp", expected, 0);
    step(0, 0, 0, 0);
    chk("t2_pulse_off", err_pulse, 0);
    send(2); send(3); send(4);
    chk("t2_relock", locked, 1);

    // Test 3: hunt and sync robustness
    step(1, 0, 0, 0);
    send(0); send(7);
    chk("t3_hunt", state, 0);
    send(2); send(4);
    chk("t3_sync", state, 1);
    chk("t3_reseed", expected, 5);
    send(5); send(1);
    chk("t3_locked", locked, 1);
    chk("t3_wrap", wrap_count, 0);

    // Test 4: gaps while locked at prev=2
    step(1, 0, 0, 0);
    send(5); send(1); send(2);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 7), 0);
    chk("t4_gap_exp", expected, 3);
    send(3);
    chk("t4_locked", locked, 1);

    // Test 5: error saturation, then clear on the same cycle as a wrap
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin send(1); send(2); send(3); send(5); end
    chk("t5_sat", err_count, 3);
    send(1); send(2); send(3); send(4); send(5);
    step(0, 1, 1, 1);
    chk("t5_clr_wrap", wrap_count, 0);
    chk("t5_clr_err", err_count, 0);

    // Test 6: reset mid-operation
    step(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) send((i % 5) + 1);
    chk("t6_wrap2", wrap_count, 2);
    step(1, 1, 2, 0);
    chk("t6_state", state, 0);
    chk("t6_locked", locked, 0);
    chk("t6_wrap", wrap_count, 0);

    // Random traffic, biased toward the correct successor to hold lock
    for (int i = 0; i < 3000; i++) begin
      int d;
      bit r, v, c;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 9) < 8) ? succ(m_prev) : $urandom_range(0, 7);
      step(r, v, d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
